// File: rtl/adder_pkg.sv
// Shared constants for the digit-serial adder: FSM state encoding and default geometry.
package adder_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;
endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder built from full-adder cells; purely combinational.
module digit_adder
  import adder_pkg::*;
#(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co
);
  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]  = x[i] ^ y[i] ^ c[i];
    assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[DIGIT];
endmodule

// File: rtl/multicycle_adder.sv
// Digit-serial add/subtract: one DIGIT-wide slice per cycle, result after WIDTH/DIGIT cycles.
// Latency start->done is N+1 cycles; start is ignored while busy, back-to-back accepted on done.
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_geometry
    $error("multicycle_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_t          state, next_state;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_nxt;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic [DIGIT-1:0] da, db, dsum;
  logic            dco;
  logic            last, ready, accept, ovf_nxt;
  int              sh;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = (state == RUN);
    done       = (state == DONE);
    ready      = (state == IDLE) || (state == DONE);
    last       = (cnt == CW'(N - 1));
    accept     = ready && start;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last)  next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Select the current digit of both operands and splice the new sum digit into a
  // private accumulator, so partial results never reach s.
  always_comb begin
    sh      = int'(cnt) * DIGIT;
    da      = DIGIT'(a_q >> sh);
    db      = DIGIT'(b_q >> sh);
    acc_nxt = (acc & ~(DMASK << sh)) | (WIDTH'(dsum) << sh);
    ovf_nxt = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
  end

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x   (da),
    .y   (db),
    .ci  (carry),
    .sum (dsum),
    .co  (dco)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + ~cin, so the borrow-in folds into the initial carry.
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      carry <= cin ^ sub;
      cnt   <= '0;
      acc   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_nxt;
      carry <= dco;
      cnt   <= cnt + 1'b1;
      if (last) begin
        s    <= acc_nxt;
        cout <= dco;
        ovf  <= ovf_nxt;
      end
    end
  end
endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder: arithmetic model plus hand-computed vectors.
module tb_multicycle_adder;
  localparam int N = 4;

  logic        clk, rst, start, start1, cin, sub;
  logic [15:0] a, b;
  logic        busy, done, cout, ovf;
  logic [15:0] s;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] s1;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
  );

  multicycle_adder #(.WIDTH(16), .DIGIT(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Result by plain integer arithmetic: true sum/difference, signed range check.
  function automatic void model_op(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic sb,
                                   output logic [15:0] rs, output logic rc, output logic ro);
    int ux, uy, sx, sy, ru, rsg;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!sb) begin
      ru  = ux + uy + int'(ci);
      rsg = sx + sy + int'(ci);
      rc  = (ru > 65535);
    end else begin
      ru  = ux - uy - int'(ci);
      rsg = sx - sy - int'(ci);
      rc  = (ru >= 0);
    end
    rs = ru[15:0];
    ro = (rsg > 32767) || (rsg < -32768);
  endfunction

  // rem = cycles left in the current operation (done cycle included).
  int          rem = 0;
  bit          chk_on = 0;
  logic [15:0] m_s = '0, p_s = '0;
  logic        m_c = 0, m_o = 0, p_c = 0, p_o = 0;

  always @(posedge clk) begin
    if (rst) begin
      chk_on = 1;
      rem = 0;
      m_s = '0; m_c = 0; m_o = 0;
    end else if (rem <= 1 && start) begin
      model_op(a, b, cin, sub, p_s, p_c, p_o);
      rem = N + 1;
    end else if (rem > 0) begin
      rem--;
      if (rem == 1) begin
        m_s = p_s; m_c = p_c; m_o = p_o;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on)
      chk("model", {12'd0, busy, done, cout, ovf, s},
          {12'd0, logic'(rem > 1), logic'(rem == 1), m_c, m_o, m_s});
  end

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
  endtask

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                       input logic ts, input logic [15:0] es, input logic ec,
                       input logic eo, input string nm);
    int lat;
    @(posedge clk); #1;
    start = 1; a = ta; b = tb_; cin = tc; sub = ts;
    @(posedge clk); #1;
    start = 0; a = ~ta; b = ~tb_; cin = ~tc; sub = ~ts;
    wait_done(lat);
    chk({nm, " latency"}, lat, 5);
    chk({nm, " s"}, s, es);
    chk({nm, " cout"}, cout, ec);
    chk({nm, " ovf"}, ovf, eo);
  endtask

  initial begin
    int lat, pulses;
    rst = 1; start = 0; start1 = 0; a = '0; b = '0; cin = 0; sub = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset s", s, 0);
    chk("reset cout", cout, 0);
    chk("reset ovf", ovf, 0);

    do_op(16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, "add basic");
    do_op(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, "add wrap");
    do_op(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, "add ovf");
    do_op(16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0, "sub neg");
    do_op(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, "sub ovf");
    do_op(16'h00FF, 16'h0F00, 1, 0, 16'h1000, 0, 0, "add cin");
    do_op(16'h1000, 16'h0001, 1, 1, 16'h0FFE, 1, 0, "sub cin");

    // start while busy must be ignored
    @(posedge clk); #1;
    start = 1; a = 16'h0001; b = 16'h0001; cin = 0; sub = 0;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1 start = 1; a = 16'hAAAA;
    @(posedge clk); #1 start = 0;
    wait_done(lat);
    chk("ignored start latency", lat, 3);
    chk("ignored start s", s, 16'h0002);

    // reset in RUN aborts with no done pulse
    @(posedge clk); #1;
    start = 1; a = 16'h0001; b = 16'h0001;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort s", s, 0);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort done pulses", pulses, 0);

    // back-to-back with start held high
    @(posedge clk); #1;
    start = 1; a = 16'h0001; b = 16'h0002; cin = 0; sub = 0;
    repeat (5) @(posedge clk);
    #1 a = 16'h0010; b = 16'h0020;
    @(negedge clk);
    chk("b2b first done", done, 1);
    chk("b2b first s", s, 16'h0003);
    @(posedge clk); #1 start = 0;
    wait_done(lat);
    chk("b2b second latency", lat, 5);
    chk("b2b second s", s, 16'h0030);

    // DIGIT == WIDTH: single step
    @(posedge clk); #1;
    start1 = 1; a = 16'h7FFF; b = 16'h0001; cin = 0; sub = 0;
    @(posedge clk); #1 start1 = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("n1 busy", busy1, 1);
    end while (!done1 && lat < 10);
    chk("n1 latency", lat, 2);
    chk("n1 s", s1, 16'h8000);
    chk("n1 cout", cout1, 0);
    chk("n1 ovf", ovf1, 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
